// File: rtl/ann_pkg.sv
// Shared definitions for the ANN sequencing controller: FSM state encoding,
// default layer dimensions, index widths and layer-select constants.
package ann_pkg;

    localparam int unsigned N_IN_DEF      = 30;
    localparam int unsigned N_HID_DEF     = 5;
    localparam int unsigned N_OUT_DEF     = 3;
    localparam int unsigned MAX_EPOCH_DEF = 255;

    localparam int unsigned NEU_W   = 3;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned EPOCH_W = 8;

    localparam logic SEL_HID = 1'b0;
    localparam logic SEL_OUT = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_H_CLR = 4'd1,
        S_H_MAC = 4'd2,
        S_H_ACT = 4'd3,
        S_O_CLR = 4'd4,
        S_O_MAC = 4'd5,
        S_O_ACT = 4'd6,
        S_ERR   = 4'd7,
        S_UPD   = 4'd8,
        S_DONE  = 4'd9
    } state_t;

endpackage

// File: rtl/ann_idx_counter.sv
// Nested neuron/input index counter. The input index wraps at its limit; the
// neuron index advances on an explicit request or, when nesting is enabled,
// on the input-index wrap. Flags report when each index sits at its limit.
module ann_idx_counter
    import ann_pkg::*;
#(
    parameter int unsigned NW = NEU_W,
    parameter int unsigned IW = IDX_W
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_in_en,
    input  logic          i_neu_en,
    input  logic          i_nest,
    input  logic [NW-1:0] i_neu_last,
    input  logic [IW-1:0] i_in_last,
    output logic [NW-1:0] o_neu,
    output logic [IW-1:0] o_in,
    output logic          o_in_last,
    output logic          o_neu_last,
    output logic          o_all_last
);

    logic [NW-1:0] r_neu;
    logic [IW-1:0] r_in;
    logic          w_neu_step;

    assign o_in_last  = (r_in == i_in_last);
    assign o_neu_last = (r_neu == i_neu_last);
    assign o_all_last = o_in_last & o_neu_last;
    assign w_neu_step = i_neu_en | (i_nest & i_in_en & o_in_last);
    assign o_neu      = r_neu;
    assign o_in       = r_in;

    // Index registers: cleared by reset or request, otherwise step and wrap.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_neu <= '0;
            r_in  <= '0;
        end else begin
            if (i_in_en) begin
                r_in <= o_in_last ? '0 : r_in + IW'(1);
            end
            if (w_neu_step) begin
                r_neu <= o_neu_last ? '0 : r_neu + NW'(1);
            end
        end
    end

endmodule

// File: rtl/ann_train_scheduler.sv
// Sequencing controller for the drowsiness-detector ANN datapath. Steps one
// shared MAC/activation unit through the hidden then output layer, samples
// the error verdict, and in training mode loops a weight-update sweep per
// epoch. Optional macro ANN_BIAS_CYCLE_EN adds one bias MAC/update slot per
// neuron (sel_input = fan-in).
module ann_train_scheduler
    import ann_pkg::*;
#(
    parameter int unsigned N_IN      = N_IN_DEF,
    parameter int unsigned N_HID     = N_HID_DEF,
    parameter int unsigned N_OUT     = N_OUT_DEF,
    parameter int unsigned MAX_EPOCH = MAX_EPOCH_DEF
) (
    input  logic               Clock,
    input  logic               Rst,
    input  logic               Start,
    input  logic               training,
    input  logic               err_ok,
    output logic               mac_clr,
    output logic               mac_en,
    output logic               act_latch,
    output logic               wupd_en,
    output logic               sel_layer,
    output logic [NEU_W-1:0]   sel_neuron,
    output logic [IDX_W-1:0]   sel_input,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic [3:0]         state,
    output logic               busy,
    output logic               done
);

`ifdef ANN_BIAS_CYCLE_EN
    localparam int unsigned N_BIAS = 1;
`else
    localparam int unsigned N_BIAS = 0;
`endif

    state_t             r_state;
    state_t             w_nxt;
    logic               r_mode;
    logic               r_layer;
    logic [EPOCH_W-1:0] r_epoch;

    logic               w_cnt_clr;
    logic               w_in_en;
    logic               w_neu_en;
    logic               w_nest;
    logic               w_in_at_last;
    logic               w_neu_at_last;
    logic               w_all_last;
    logic [NEU_W-1:0]   w_neu_lim;
    logic [IDX_W-1:0]   w_in_lim;

    // Index limits follow the layer currently addressed; fan-in includes the bias slot when enabled.
    assign w_in_lim  = (r_layer == SEL_OUT) ? IDX_W'(N_HID - 1 + N_BIAS) : IDX_W'(N_IN - 1 + N_BIAS);
    assign w_neu_lim = (r_layer == SEL_OUT) ? NEU_W'(N_OUT - 1) : NEU_W'(N_HID - 1);

    // One counter serves both sweeps: forward steps neurons on activation,
    // update nests neurons under inputs.
    ann_idx_counter #(
        .NW (NEU_W),
        .IW (IDX_W)
    ) u_idx (
        .i_clk      (Clock),
        .i_rst_n    (Rst),
        .i_clr      (w_cnt_clr),
        .i_in_en    (w_in_en),
        .i_neu_en   (w_neu_en),
        .i_nest     (w_nest),
        .i_neu_last (w_neu_lim),
        .i_in_last  (w_in_lim),
        .o_neu      (sel_neuron),
        .o_in       (sel_input),
        .o_in_last  (w_in_at_last),
        .o_neu_last (w_neu_at_last),
        .o_all_last (w_all_last)
    );

    assign sel_layer = r_layer;
    assign epoch_cnt = r_epoch;
    assign state     = r_state;
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = (r_state == S_DONE);

    // State, run mode, layer select and epoch count registers.
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_layer <= SEL_HID;
            r_epoch <= '0;
        end else begin
            r_state <= w_nxt;
            case (r_state)
                S_IDLE: begin
                    r_mode  <= training;
                    r_layer <= SEL_HID;
                    r_epoch <= '0;
                end
                S_H_ACT: begin
                    if (w_neu_at_last) r_layer <= SEL_OUT;
                end
                // Update sweep runs output layer first, then hidden; the hidden wrap closes the epoch.
                S_UPD: begin
                    if (w_all_last) begin
                        if (r_layer == SEL_OUT) r_layer <= SEL_HID;
                        else                    r_epoch <= r_epoch + EPOCH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and per-state strobes / counter controls.
    always_comb begin
        w_nxt     = r_state;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        act_latch = 1'b0;
        wupd_en   = 1'b0;
        w_cnt_clr = 1'b0;
        w_in_en   = 1'b0;
        w_neu_en  = 1'b0;
        w_nest    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (Start) w_nxt = S_H_CLR;
            end
            S_H_CLR: begin
                mac_clr = 1'b1;
                w_nxt   = S_H_MAC;
            end
            S_H_MAC: begin
                mac_en  = 1'b1;
                w_in_en = 1'b1;
                if (w_in_at_last) w_nxt = S_H_ACT;
            end
            S_H_ACT: begin
                act_latch = 1'b1;
                w_neu_en  = 1'b1;
                w_nxt     = w_neu_at_last ? S_O_CLR : S_H_CLR;
            end
            S_O_CLR: begin
                mac_clr = 1'b1;
                w_nxt   = S_O_MAC;
            end
            S_O_MAC: begin
                mac_en  = 1'b1;
                w_in_en = 1'b1;
                if (w_in_at_last) w_nxt = S_O_ACT;
            end
            S_O_ACT: begin
                act_latch = 1'b1;
                w_neu_en  = 1'b1;
                w_nxt     = w_neu_at_last ? S_ERR : S_O_CLR;
            end
            S_ERR: begin
                if (!r_mode || err_ok || (r_epoch == EPOCH_W'(MAX_EPOCH))) w_nxt = S_DONE;
                else                                                      w_nxt = S_UPD;
            end
            S_UPD: begin
                wupd_en = 1'b1;
                w_in_en = 1'b1;
                w_nest  = 1'b1;
                if ((r_layer == SEL_HID) && w_all_last) w_nxt = S_H_CLR;
            end
            S_DONE: begin
                if (!Start) w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/ann_train_scheduler.md
Name: ann_train_scheduler

Overview:
- Sequencing controller for the drowsiness-detector ANN datapath: 30 inputs, 5 hidden neurons, 3 outputs.
- Steps a single shared MAC/activation unit through the hidden layer, then the output layer.
- Samples the datapath's error verdict after each forward pass.
- In training mode, sweeps a weight-update pass and repeats per epoch until error is in tolerance or the epoch limit is reached.
- Sits between the top-level Start/training controls and the ANN datapath; replaces free-running per-layer enables.

Parameters:
- N_IN, 30, input vector length.
- N_HID, 5, hidden-layer neurons.
- N_OUT, 3, output-layer neurons.
- MAX_EPOCH, 255, maximum training epochs (8-bit counter).

Ports:
- Clock  in  1  single system clock, rising edge.
- Rst  in  1  synchronous, active-low reset.
- Start  in  1  level request; run begins when high in IDLE.
- training  in  1  1 = train (forward + update loop), 0 = inference (single forward pass). Sampled at run start.
- err_ok  in  1  datapath verdict: all outputs within tolerance of target. Valid in ERR.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate input[sel_input] × weight[sel_layer][sel_neuron][sel_input].
- act_latch  out  1  apply activation and latch the result into the layer output register.
- wupd_en  out  1  update the weight addressed by sel_layer/sel_neuron/sel_input.
- sel_layer  out  1  0 = hidden, 1 = output.
- sel_neuron  out  3  neuron index.
- sel_input  out  5  input index (hidden-layer input index for the output layer).
- epoch_cnt  out  8  completed training epochs.
- state  out  4  FSM encoding, for debug/top-level visibility.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (Rst=0 at a Clock edge):
  - state=IDLE; all strobes 0; selects 0; epoch_cnt=0; busy=0; done=0.
  - Reset mid-run aborts immediately; no further strobes are issued.
- State encodings: IDLE=0, H_CLR=1, H_MAC=2, H_ACT=3, O_CLR=4, O_MAC=5, O_ACT=6, ERR=7, UPD=8, DONE=9. Values 10–15 are illegal and go to IDLE.
- IDLE:
  - Start=1 → H_CLR.
  - Latch training into mode_r.
  - Clear epoch_cnt, sel_neuron, sel_input.
- H_CLR:
  - mac_clr=1 for one cycle.
  - sel_layer=0, sel_input=0.
  - → H_MAC.
- H_MAC:
  - mac_en=1 for N_IN cycles; sel_input counts 0..N_IN-1.
  - After index N_IN-1 → H_ACT.
- H_ACT:
  - act_latch=1 for one cycle.
  - If sel_neuron<N_HID-1: sel_neuron++, → H_CLR.
  - Else: sel_neuron=0, → O_CLR.
- O_CLR/O_MAC/O_ACT: same as the hidden sequence, with these differences:
  - sel_layer=1.
  - MAC runs N_HID cycles.
  - Neuron loop runs to N_OUT-1.
  - After the last neuron → ERR.
- Forward-pass latency from leaving IDLE to entering ERR:
  - N_HID·(N_IN+2) + N_OUT·(N_HID+2) = 160+21 = 181 cycles.
- ERR (1 cycle, samples err_ok):
  - mode_r=0 → DONE.
  - err_ok=1 → DONE.
  - epoch_cnt==MAX_EPOCH → DONE.
  - Otherwise → UPD.
- UPD:
  - wupd_en=1 every cycle.
  - Output-layer weights first (sel_layer=1): N_OUT×N_HID = 15 cycles, neuron outer loop, input inner loop.
  - Then hidden-layer weights (sel_layer=0): N_HID×N_IN = 150 cycles.
  - Total 165 cycles.
  - On the last update: epoch_cnt++, → H_CLR.
- DONE:
  - done=1.
  - Holds until Start=0, then → IDLE.
  - Start held high in DONE does not restart the run.
- Start deasserted mid-run is ignored; the run completes.
- Strobes are mutually exclusive; at most one of mac_clr/mac_en/act_latch/wupd_en is high per cycle.
- Selects are registered and aligned with their strobe in the same cycle.

Optional Feature:
- Macro: ANN_BIAS_CYCLE_EN.
- Defined:
  - Each MAC phase gets one extra mac_en cycle with sel_input=N_IN (hidden) or N_HID (output), addressing the bias weight at input value 1.
  - UPD also covers one bias per neuron.
  - Forward latency becomes 189 cycles; UPD becomes 173 cycles.
- Undefined: no bias cycles; latencies as above.

Decomposition:
- Shared package ann_pkg holds:
  - the state enum (4-bit);
  - the N_IN/N_HID/N_OUT defaults;
  - the index widths;
  - the SEL_HID/SEL_OUT constants.
- One natural sub-module: ann_idx_counter, a nested neuron/input index counter with programmable limits and a last-index flag. It is instanced for both the forward and update sweeps.

Test Plan:
- Reset then Start=1, training=0:
  - 5 hidden bursts of mac_en (30 cycles each), 3 output bursts (5 cycles each).
  - ERR at cycle 181 after leaving IDLE; DONE; epoch_cnt=0; no wupd_en.
- training=1, err_ok held 1: single forward pass, then DONE; zero wupd_en cycles.
- training=1, err_ok=0 for 2 epochs, then 1:
  - Exactly 2 UPD sweeps of 165 wupd_en cycles each.
  - epoch_cnt=2 at DONE.
- training=1, err_ok=0 forever: DONE with epoch_cnt=255 after 255 update sweeps.
- Rst=0 pulsed during H_MAC (sel_input=12):
  - Next cycle state=IDLE, all strobes 0.
  - Start held high restarts cleanly at H_CLR.
- Start held high in DONE: stays in DONE. Start=0 → IDLE next cycle. Start=1 → new run with epoch_cnt=0.
